// File: rtl/reg_dump_streamer_if.sv
// Character stream between the register-dump streamer and the VGA character
// renderer. One character moves per cycle in which charValid && charReady.
//   charValid    : charCode/charRegIndex/charPos are valid (master -> slave)
//   charReady    : renderer accepts the current character  (slave -> master)
//   charCode     : ASCII code of the current character
//   charRegIndex : register the character belongs to (separator: preceding register)
//   charPos      : 0-based ordinal of the character within the dump
interface reg_dump_streamer_if;
  logic       charValid;
  logic       charReady;
  logic [7:0] charCode;
  logic [3:0] charRegIndex;
  logic [5:0] charPos;

  modport master (
    output charValid,
    output charCode,
    output charRegIndex,
    output charPos,
    input  charReady
  );

  modport slave (
    input  charValid,
    input  charCode,
    input  charRegIndex,
    input  charPos,
    output charReady
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// Snapshots the register file's VGA debug bus on a start pulse and streams it
// to the character renderer as uppercase hex digits, four per register, with
// SEP_CHAR between registers (none after the last one).
// Ports:
//   clk          : system clock, all state changes on posedge
//   rst          : asynchronous active-low reset
//   start        : request a dump, honoured only while idle
//   registersVGA : NUM_REGS x 16-bit bus, register 0 in the top 16 bits
//   busy         : high while characters are being streamed
//   done         : one-cycle pulse after the last character is accepted
//   chr          : character stream (master side)
module reg_dump_streamer #(
  parameter int unsigned NUM_REGS = 11,
  parameter logic [7:0]  SEP_CHAR = 8'h20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_REGS*16-1:0]   registersVGA,
  output logic                     busy,
  output logic                     done,
  reg_dump_streamer_if.master      chr
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  localparam logic [3:0] LAST_REG = 4'(NUM_REGS - 1);

  state_e                   state_q,   state_d;
  logic [3:0]               regIdx_q,  regIdx_d;
  logic [2:0]               nibIdx_q,  nibIdx_d;
  logic [5:0]               charPos_q, charPos_d;
  logic [NUM_REGS*16-1:0]   shadow_q,  shadow_d;

  logic [15:0] word;
  logic [3:0]  nib;
  logic [7:0]  hexCode;

  // Select the snapshot word of the current register (register 0 is MSB-most).
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (regIdx_q == 4'(i)) begin
        word = shadow_q[(NUM_REGS-1-i)*16 +: 16];
      end
    end
  end

  always_comb begin
    nib = '0;
    case (nibIdx_q)
      3'd0:    nib = word[15:12];
      3'd1:    nib = word[11:8];
      3'd2:    nib = word[7:4];
      3'd3:    nib = word[3:0];
      default: nib = '0;
    endcase
    // 8'h37 + 10 = 'A'
    hexCode = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  end

  always_comb begin
    state_d          = state_q;
    regIdx_d         = regIdx_q;
    nibIdx_d         = nibIdx_q;
    charPos_d        = charPos_q;
    shadow_d         = shadow_q;
    chr.charValid    = 1'b0;
    chr.charCode     = '0;
    chr.charRegIndex = '0;
    chr.charPos      = '0;
    busy             = 1'b0;
    done             = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = registersVGA;
          regIdx_d  = '0;
          nibIdx_d  = '0;
          charPos_d = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        chr.charValid    = 1'b1;
        busy             = 1'b1;
        chr.charCode     = (nibIdx_q == 3'd4) ? SEP_CHAR : hexCode;
        chr.charRegIndex = regIdx_q;
        chr.charPos      = charPos_q;
        if (chr.charReady) begin
          charPos_d = charPos_q + 6'd1;
          if (nibIdx_q < 3'd3) begin
            nibIdx_d = nibIdx_q + 3'd1;
          end else if (nibIdx_q == 3'd3) begin
            // Last digit of the last register ends the dump: no trailing separator.
            if (regIdx_q == LAST_REG) begin
              state_d = DONE;
            end else begin
              nibIdx_d = 3'd4;
            end
          end else begin
            nibIdx_d = '0;
            regIdx_d = regIdx_q + 4'd1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      regIdx_q  <= '0;
      nibIdx_q  <= '0;
      charPos_q <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      regIdx_q  <= regIdx_d;
      nibIdx_q  <= nibIdx_d;
      charPos_q <= charPos_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
module tb_reg_dump_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 11-register instance
  logic         start0;
  logic [175:0] regs0;
  logic         busy0, done0;
  reg_dump_streamer_if if0();

  reg_dump_streamer #(.NUM_REGS(11), .SEP_CHAR(8'h20)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .registersVGA(regs0),
    .busy(busy0), .done(done0), .chr(if0)
  );

  // single-register instance
  logic        start1;
  logic [15:0] regs1;
  logic        busy1, done1;
  reg_dump_streamer_if if1();

  reg_dump_streamer #(.NUM_REGS(1), .SEP_CHAR(8'h20)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .registersVGA(regs1),
    .busy(busy1), .done(done1), .chr(if1)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] code;
    logic [3:0] ri;
    logic [5:0] pos;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] val;
    string       exp;
  } vec_t;
  vec_t vt[6];

  localparam string DUMP_A = "0000 1234 5678 9ABC DEF0 1111 2222 3333 4444 5555 ABCD";
  localparam string DUMP_B = "0000 FFFF 5678 9ABC DEF0 1111 2222 3333 4444 5555 ABCD";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string d;
    d = "0123456789ABCDEF";
    return d[int'(n)];
  endfunction

  task automatic push_model(input logic [175:0] r);
    logic [15:0] w;
    int pos;
    pos = 0;
    for (int i = 0; i < 11; i++) begin
      w = r[175-16*i -: 16];
      for (int n = 0; n < 4; n++) begin
        sb.push_back('{hexc(w[15-4*n -: 4]), 4'(i), 6'(pos)});
        pos++;
      end
      if (i < 10) begin
        sb.push_back('{8'h20, 4'(i), 6'(pos)});
        pos++;
      end
    end
  endtask

  // mode 0: charReady always 1; mode 1: 1,0,0,1,0,0,...
  // restart_pos >= 0: pulse start at that charPos and in the DONE cycle.
  // rst_pos >= 0: assert reset mid-dump at that charPos.
  // change_cyc > 0: overwrite R1 that many cycles after start.
  task automatic run0(input int mode, input int restart_pos, input int rst_pos,
                      input int change_cyc, output string got);
    int   cyc, valid_cycles, stalls;
    bit   last_acc, fin, ready;
    exp_t front;
    cyc = 0; valid_cycles = 0; stalls = 0; last_acc = 0; fin = 0;
    got = "";
    @(negedge clk);
    check("idle_valid", if0.charValid, 1'b0);
    check("idle_busy", busy0, 1'b0);
    start0 = 1'b1;
    push_model(regs0);
    @(negedge clk);
    start0 = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (cyc == change_cyc) regs0[159:144] = 16'hFFFF;
      if (last_acc) begin
        check("done_pulse", done0, 1'b1);
        check("done_valid", if0.charValid, 1'b0);
        check("done_busy", busy0, 1'b0);
        check("sb_drained", sb.size(), 0);
        check("valid_cycles", valid_cycles, 54 + stalls);
        if (restart_pos >= 0) start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("done_once", done0, 1'b0);
        check("after_done_valid", if0.charValid, 1'b0);
        check("after_done_busy", busy0, 1'b0);
        @(negedge clk);
        check("no_restart", if0.charValid, 1'b0);
        fin = 1;
      end else if (!if0.charValid || sb.size() == 0) begin
        check("stream_valid", if0.charValid, 1'b1);
        check("sb_nonempty", sb.size() != 0, 1'b1);
        fin = 1;
      end else begin
        valid_cycles++;
        front = sb[0];
        check("charCode", if0.charCode, front.code);
        check("charRegIndex", if0.charRegIndex, front.ri);
        check("charPos", if0.charPos, front.pos);
        check("busy", busy0, 1'b1);
        if (rst_pos == int'(front.pos)) begin
          if0.charReady = 1'b1;
          #2 rst = 1'b0;
          #1;
          check("rst_valid", if0.charValid, 1'b0);
          check("rst_busy", busy0, 1'b0);
          check("rst_done", done0, 1'b0);
          sb.delete();
          @(negedge clk);
          check("rst_held_done", done0, 1'b0);
          rst = 1'b1;
          fin = 1;
        end else begin
          start0 = (restart_pos == int'(front.pos));
          ready = (mode == 0) ? 1'b1 : ((valid_cycles % 3) == 1);
          if0.charReady = ready;
          if (ready) begin
            got = {got, $sformatf("%c", front.code)};
            void'(sb.pop_front());
            if (front.pos == 6'd53) last_acc = 1;
          end else begin
            stalls++;
          end
          @(negedge clk);
        end
      end
    end
    if (!fin) begin
      total++;
      $display("FAIL run0_timeout: got %0d cycles required completion", cyc);
    end
    start0 = 1'b0;
    sb.delete();
  endtask

  task automatic run1(input logic [15:0] val, input string exp);
    string got;
    int    n;
    bit    seen_done;
    got = ""; n = 0; seen_done = 0;
    @(negedge clk);
    check("r1_idle_valid", if1.charValid, 1'b0);
    regs1 = val;
    start1 = 1'b1;
    if1.charReady = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    regs1 = ~val;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (if1.charValid) begin
        check("r1_pos", if1.charPos, n);
        check("r1_regidx", if1.charRegIndex, 0);
        got = {got, $sformatf("%c", if1.charCode)};
        n++;
      end else if (done1) begin
        seen_done = 1;
      end
      @(negedge clk);
    end
    check_str("r1_chars", got, exp);
    check("r1_count", n, 4);
    check("r1_done_seen", seen_done, 1'b1);
    check("r1_done_once", done1, 1'b0);
  endtask

  initial begin
    string got;
    vt[0] = '{16'h00F0, "00F0"};
    vt[1] = '{16'h1234, "1234"};
    vt[2] = '{16'hABCD, "ABCD"};
    vt[3] = '{16'h9A5F, "9A5F"};
    vt[4] = '{16'hFFFF, "FFFF"};
    vt[5] = '{16'h0000, "0000"};

    rst = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    regs0 = {16'h0000, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1111,
             16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'hABCD};
    regs1 = '0;
    if0.charReady = 1'b1;
    if1.charReady = 1'b0;
    #12;
    check("rst_charValid", if0.charValid, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_charCode", if0.charCode, 8'h00);
    check("rst_charRegIndex", if0.charRegIndex, 4'h0);
    check("rst_charPos", if0.charPos, 6'h00);
    check("rst_valid1", if1.charValid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    // charReady high while idle must not start anything
    repeat (3) @(negedge clk);
    check("idle_ready_ignored", if0.charValid, 1'b0);

    run0(0, -1, -1, -1, got);
    check_str("dump_ready", got, DUMP_A);

    run0(1, -1, -1, -1, got);
    check_str("dump_stall", got, DUMP_A);

    run0(0, -1, -1, 2, got);
    check_str("dump_snapshot", got, DUMP_A);
    run0(0, -1, -1, -1, got);
    check_str("dump_second", got, DUMP_B);
    check_str("dump_second_r1", got.substr(5, 8), "FFFF");
    regs0[159:144] = 16'h1234;

    run0(0, 10, -1, -1, got);
    check_str("dump_restart_ignored", got, DUMP_A);

    run0(0, -1, 20, -1, got);
    run0(0, -1, -1, -1, got);
    check_str("dump_after_reset", got, DUMP_A);

    for (int i = 0; i < 6; i++) run1(vt[i].val, vt[i].exp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
